// File: rtl/global_types.sv
// -----------------------------------------------------------------------------
// global_types
// Shared type definitions for the decode pipeline.
//   - Control-vector field enums and the packed ctrl_t, ordered
//     {rf_we, sel_wa, sel_alu_b, sel_result, sel_pc, alu_ctrl} (12 bits).
//   - MIPS opcode / funct constants for the supported instruction subset.
//   - decoded_instr_t: everything the decode stage hands to execute.
//   - Helpers classifying instructions that touch the HI/LO unit.
// -----------------------------------------------------------------------------
package global_types;

    typedef enum logic [1:0] {
        WA_RT = 2'd0,
        WA_RD = 2'd1,
        WA_RA = 2'd2
    } sel_wa_e;

    typedef enum logic {
        ALUB_REG = 1'b0,
        ALUB_IMM = 1'b1
    } sel_alu_b_e;

    typedef enum logic [2:0] {
        RES_ALU = 3'd0,
        RES_RD  = 3'd1,
        RES_PC8 = 3'd2,
        RES_HI  = 3'd3,
        RES_LO  = 3'd4
    } sel_result_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } sel_pc_e;

    // ALU_NONE is the don't-care code for instructions that never use the ALU.
    // ALU_MULTU / ALU_DIVU are unique to the HI/LO producers.
    typedef enum logic [2:0] {
        ALU_AND   = 3'd0,
        ALU_OR    = 3'd1,
        ALU_ADD   = 3'd2,
        ALU_MULTU = 3'd3,
        ALU_DIVU  = 3'd4,
        ALU_NONE  = 3'd5,
        ALU_SUB   = 3'd6,
        ALU_SLT   = 3'd7
    } alu_ctrl_e;

    typedef struct packed {
        logic        rf_we;
        sel_wa_e     sel_wa;
        sel_alu_b_e  sel_alu_b;
        sel_result_e sel_result;
        sel_pc_e     sel_pc;
        alu_ctrl_e   alu_ctrl;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [25:0] jaddr;
        logic        illegal;
    } decoded_instr_t;

    function automatic ctrl_t make_ctrl(input logic        rf_we,
                                        input sel_wa_e     sel_wa,
                                        input sel_alu_b_e  sel_alu_b,
                                        input sel_result_e sel_result,
                                        input sel_pc_e     sel_pc,
                                        input alu_ctrl_e   alu_ctrl);
        ctrl_t c;
        c.rf_we      = rf_we;
        c.sel_wa     = sel_wa;
        c.sel_alu_b  = sel_alu_b;
        c.sel_result = sel_result;
        c.sel_pc     = sel_pc;
        c.alu_ctrl   = alu_ctrl;
        return c;
    endfunction

    // MULTU / DIVU: start a multi-cycle HI/LO computation.
    function automatic logic is_md_op(input logic [31:0] instr);
        return (instr[31:26] == OP_RTYPE) &&
               (instr[5:0] == FN_MULTU || instr[5:0] == FN_DIVU);
    endfunction

    // Anything that reads or writes HI/LO and so must wait for a pending result.
    function automatic logic uses_hilo(input logic [31:0] instr);
        return is_md_op(instr) ||
               ((instr[31:26] == OP_RTYPE) &&
                (instr[5:0] == FN_MFHI || instr[5:0] == FN_MFLO));
    endfunction

endpackage

// File: rtl/instr_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// instr_ctrl_decoder
// Purely combinational mapping from a raw MIPS word to the control tuple and
// extracted fields. Unsupported encodings flag illegal and decode to a
// harmless no-write, PC+4 tuple; fields are always passed through.
//   instr  in  32  raw instruction word
//   dec    out     decoded_instr_t
// -----------------------------------------------------------------------------
module instr_ctrl_decoder
    import global_types::*;
(
    input  logic [31:0]    instr,
    output decoded_instr_t dec
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // NOTE: every output gets a default before the case so no path leaves a
    // field unassigned, which would otherwise infer a latch.
    always_comb begin
        dec.rs      = instr[25:21];
        dec.rt      = instr[20:16];
        dec.rd      = instr[15:11];
        dec.shamt   = instr[10:6];
        dec.imm     = {{16{instr[15]}}, instr[15:0]};
        dec.jaddr   = instr[25:0];
        dec.ctrl    = make_ctrl(1'b0, WA_RT, ALUB_REG, RES_ALU, PC_PLUS4, ALU_NONE);
        dec.illegal = 1'b1;

        case (opcode)
            OP_LW: begin
                dec.ctrl    = make_ctrl(1'b1, WA_RT, ALUB_IMM, RES_RD, PC_PLUS4, ALU_ADD);
                dec.illegal = 1'b0;
            end
            OP_SW: begin
                dec.ctrl    = make_ctrl(1'b0, WA_RT, ALUB_IMM, RES_ALU, PC_PLUS4, ALU_ADD);
                dec.illegal = 1'b0;
            end
            OP_ADDI: begin
                dec.ctrl    = make_ctrl(1'b1, WA_RT, ALUB_IMM, RES_ALU, PC_PLUS4, ALU_ADD);
                dec.illegal = 1'b0;
            end
            OP_BEQ: begin
                dec.ctrl    = make_ctrl(1'b0, WA_RT, ALUB_REG, RES_ALU, PC_BRANCH, ALU_SUB);
                dec.illegal = 1'b0;
            end
            OP_J: begin
                dec.ctrl    = make_ctrl(1'b0, WA_RT, ALUB_REG, RES_ALU, PC_JUMP, ALU_NONE);
                dec.illegal = 1'b0;
            end
            OP_JAL: begin
                dec.ctrl    = make_ctrl(1'b1, WA_RA, ALUB_REG, RES_PC8, PC_JUMP, ALU_NONE);
                dec.illegal = 1'b0;
            end
            OP_RTYPE: begin
                dec.illegal = 1'b0;
                case (funct)
                    FN_ADD:   dec.ctrl = make_ctrl(1'b1, WA_RD, ALUB_REG, RES_ALU, PC_PLUS4, ALU_ADD);
                    FN_SUB:   dec.ctrl = make_ctrl(1'b1, WA_RD, ALUB_REG, RES_ALU, PC_PLUS4, ALU_SUB);
                    FN_AND:   dec.ctrl = make_ctrl(1'b1, WA_RD, ALUB_REG, RES_ALU, PC_PLUS4, ALU_AND);
                    FN_OR:    dec.ctrl = make_ctrl(1'b1, WA_RD, ALUB_REG, RES_ALU, PC_PLUS4, ALU_OR);
                    FN_SLT:   dec.ctrl = make_ctrl(1'b1, WA_RD, ALUB_REG, RES_ALU, PC_PLUS4, ALU_SLT);
                    FN_JR:    dec.ctrl = make_ctrl(1'b0, WA_RT, ALUB_REG, RES_ALU, PC_JR, ALU_NONE);
                    FN_DIVU:  dec.ctrl = make_ctrl(1'b0, WA_RT, ALUB_REG, RES_ALU, PC_PLUS4, ALU_DIVU);
                    FN_MULTU: dec.ctrl = make_ctrl(1'b0, WA_RT, ALUB_REG, RES_ALU, PC_PLUS4, ALU_MULTU);
                    FN_MFHI:  dec.ctrl = make_ctrl(1'b1, WA_RD, ALUB_REG, RES_HI, PC_PLUS4, ALU_NONE);
                    FN_MFLO:  dec.ctrl = make_ctrl(1'b1, WA_RD, ALUB_REG, RES_LO, PC_PLUS4, ALU_NONE);
                    default:  dec.illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// -----------------------------------------------------------------------------
// instruction_decode_stage
// One-deep registered decode stage with valid/ready handshakes on both sides
// and a HI/LO busy counter that stalls HI/LO users behind MULTU/DIVU.
//   clk, rstn            clock, async active-low reset
//   flush                drop the held instruction (blocks intake this cycle)
//   in_valid/in_ready    fetch handshake, in_instr is the raw word
//   out_valid/out_ready  execute handshake
//   out_ctrl             {rf_we, sel_wa, sel_alu_b, sel_result, sel_pc, alu_ctrl}
//   out_rs/rt/rd/shamt   instruction fields, out_imm sign-extended, out_jaddr
//   out_illegal          unsupported opcode/funct
//   md_busy              HI/LO result still pending
// -----------------------------------------------------------------------------
module instruction_decode_stage
    import global_types::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_ctrl,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_shamt,
    output logic [31:0] out_imm,
    output logic [25:0] out_jaddr,
    output logic        out_illegal,
    output logic        md_busy
);

    localparam int               CNT_W   = $clog2(MD_LATENCY + 2);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY);

    decoded_instr_t   dec;
    decoded_instr_t   held_d, held_q;
    logic             out_valid_d, out_valid_q;
    logic [CNT_W-1:0] md_cnt_d, md_cnt_q;

    logic held_is_md;
    logic hazard;
    logic accept_in;
    logic accept_out;

    instr_ctrl_decoder u_decoder (
        .instr (in_instr),
        .dec   (dec)
    );

    assign md_busy    = (md_cnt_q != '0);
    // A held MULTU/DIVU has not loaded the counter yet, so HI/LO users must
    // also wait behind it, even in the cycle it is being handed off.
    assign held_is_md = out_valid_q &&
                        (held_q.ctrl.alu_ctrl == ALU_MULTU || held_q.ctrl.alu_ctrl == ALU_DIVU);
    assign hazard     = uses_hilo(in_instr) && (md_busy || held_is_md);
    assign in_ready   = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept_in  = in_valid && in_ready;
    // A flushed instruction never counts as delivered.
    assign accept_out = out_valid_q && out_ready && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        held_d      = held_q;
        md_cnt_d    = md_cnt_q;

        if (accept_in) begin
            out_valid_d = 1'b1;
            held_d      = dec;
        end else if (flush || accept_out) begin
            out_valid_d = 1'b0;
        end

        // A new load wins over the final decrement.
        if (accept_out && held_is_md) begin
            md_cnt_d = MD_LOAD;
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            md_cnt_q    <= '0;
            // NOTE: the held payload is reset too, because its outputs must
            // read as zero while in reset, not merely be masked by out_valid.
            held_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            md_cnt_q    <= md_cnt_d;
            held_q      <= held_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ctrl    = held_q.ctrl;
    assign out_rs      = held_q.rs;
    assign out_rt      = held_q.rt;
    assign out_rd      = held_q.rd;
    assign out_shamt   = held_q.shamt;
    assign out_imm     = held_q.imm;
    assign out_jaddr   = held_q.jaddr;
    assign out_illegal = held_q.illegal;

endmodule
